mem_bank_arbiter: RTL and testbench



---
 rtl/mem_bank_arbiter_pkg.sv | 9 +
 rtl/mem_bank_rr_arb.sv | 47 ++++
 rtl/mem_bank_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_bank_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bank_arbiter_pkg.sv
// Shared helpers for the memory-bank arbiter slice.
package mem_bank_arbiter_pkg;

    // Index width that stays legal (>= 1 bit) even for a single requester.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bank_rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts after the last granted port.
module mem_bank_rr_arb
    import mem_bank_arbiter_pkg::*;
#(
    parameter int unsigned NumPorts = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumPorts-1:0] req_i,
    input  logic                en_i,
    output logic [NumPorts-1:0] gnt_o
);

    localparam int unsigned IdxW = idx_width(NumPorts);
    localparam logic [IdxW-1:0] LastRst = IdxW'(NumPorts - 1);

    logic [IdxW-1:0] last_q, last_d;
    logic [IdxW-1:0] pick;
    int unsigned     idx;
    logic            found;

    always_comb begin
        gnt_o  = '0;
        last_d = last_q;
        pick   = '0;
        idx    = 0;
        found  = 1'b0;
        if (en_i) begin
            for (int unsigned off = 1; off <= NumPorts; off++) begin
                idx = int'(last_q) + off;
                if (idx >= NumPorts) idx = idx - NumPorts;
                pick = IdxW'(idx);
                if (!found && req_i[pick]) begin
                    gnt_o[pick] = 1'b1;
                    last_d      = pick;
                    found       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) last_q <= LastRst;
        else         last_q <= last_d;
    end

endmodule

// File: rtl/mem_bank_arbiter.sv
// Shares one latency-1 SRAM macro between NumPorts req/gnt requesters; zero-fills
// the macro after reset or clear_i before any requester is granted.
module mem_bank_arbiter
    import mem_bank_arbiter_pkg::*;
#(
    parameter  int unsigned NumPorts  = 2,
    parameter  int unsigned NumWords  = 512,
    parameter  int unsigned DataWidth = 256,
    localparam int unsigned AW        = $clog2(NumWords),
    localparam int unsigned BW        = DataWidth / 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clear_i,
    output logic                               busy_o,
    input  logic [NumPorts-1:0]                req_i,
    output logic [NumPorts-1:0]                gnt_o,
    input  logic [NumPorts-1:0][AW-1:0]        addr_i,
    input  logic [NumPorts-1:0]                we_i,
    input  logic [NumPorts-1:0][DataWidth-1:0] wdata_i,
    input  logic [NumPorts-1:0][BW-1:0]        be_i,
    output logic [NumPorts-1:0]                rvalid_o,
    output logic [NumPorts-1:0][DataWidth-1:0] rdata_o,
    output logic                               sram_req_o,
    output logic                               sram_we_o,
    output logic [AW-1:0]                      sram_addr_o,
    output logic [DataWidth-1:0]               sram_wdata_o,
    output logic [BW-1:0]                      sram_be_o,
    input  logic [DataWidth-1:0]               sram_rdata_i
);

    typedef enum logic {
        StInit,
        StRun
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       init_cnt_q, init_cnt_d;
    logic [NumPorts-1:0] rvalid_q, rvalid_d;
    logic [NumPorts-1:0] arb_gnt;
    logic                arb_en;

    // Gating the arbiter with rst_ni keeps gnt_o and last_q updates quiet in reset.
    assign arb_en = rst_ni && (state_q == StRun);

    mem_bank_rr_arb #(
        .NumPorts(NumPorts)
    ) u_arb (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .req_i (req_i),
        .en_i  (arb_en),
        .gnt_o (arb_gnt)
    );

    assign gnt_o    = arb_gnt;
    assign rvalid_o = rvalid_q & {NumPorts{rst_ni}};
    assign rdata_o  = {NumPorts{sram_rdata_i}};

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        rvalid_d     = arb_gnt;
        busy_o       = 1'b1;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        unique case (state_q)
            StInit: begin
                sram_req_o  = 1'b1;
                sram_we_o   = 1'b1;
                sram_addr_o = init_cnt_q;
                sram_be_o   = '1;
                if (clear_i) begin
                    init_cnt_d = '0;
                end else if (init_cnt_q == AW'(NumWords - 1)) begin
                    state_d    = StRun;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + AW'(1);
                end
            end
            StRun: begin
                busy_o     = 1'b0;
                sram_req_o = |req_i;
                for (int unsigned p = 0; p < NumPorts; p++) begin
                    if (arb_gnt[p]) begin
                        sram_we_o    = we_i[p];
                        sram_addr_o  = addr_i[p];
                        sram_wdata_o = wdata_i[p];
                        sram_be_o    = be_i[p];
                    end
                end
                if (clear_i) begin
                    state_d    = StInit;
                    init_cnt_d = '0;
                end
            end
            default: state_d = StInit;
        endcase
        if (!rst_ni) begin
            sram_req_o = 1'b0;
            busy_o     = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rvalid_q   <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Scoreboard bench for mem_bank_arbiter with a behavioural latency-1 SRAM.
module tb_mem_bank_arbiter;

    localparam int NP = 2;
    localparam int NW = 8;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int BW = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   clr;
    logic                   busy;
    logic [NP-1:0]          req;
    logic [NP-1:0]          gnt;
    logic [NP-1:0][AW-1:0]  addr;
    logic [NP-1:0]          we;
    logic [NP-1:0][DW-1:0]  wdata;
    logic [NP-1:0][BW-1:0]  be;
    logic [NP-1:0]          rvalid;
    logic [NP-1:0][DW-1:0]  rdata;
    logic                   sram_req, sram_we;
    logic [AW-1:0]          sram_addr;
    logic [DW-1:0]          sram_wdata;
    logic [BW-1:0]          sram_be;
    logic [DW-1:0]          sram_rdata;

    mem_bank_arbiter #(
        .NumPorts (NP),
        .NumWords (NW),
        .DataWidth(DW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clr),
        .busy_o      (busy),
        .req_i       (req),
        .gnt_o       (gnt),
        .addr_i      (addr),
        .we_i        (we),
        .wdata_i     (wdata),
        .be_i        (be),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .sram_req_o  (sram_req),
        .sram_we_o   (sram_we),
        .sram_addr_o (sram_addr),
        .sram_wdata_o(sram_wdata),
        .sram_be_o   (sram_be),
        .sram_rdata_i(sram_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] sram_mem [NW];
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < BW; b++)
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    typedef struct {
        int            port;
        bit            rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;
    bit            m_init;
    int            m_cnt;
    int            m_last;
    logic [DW-1:0] ref_mem [NW];
    logic          obs_busy;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    // One clock cycle: inputs already driven at negedge, checked #1 later.
    task automatic tick();
        int            g;
        exp_t          e;
        logic [NP-1:0] eg;
        g = -1;
        #1;
        obs_busy = busy;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("rvalid", 64'(rvalid), 64'(1 << e.port));
            if (e.rd) check_eq("rdata", 64'(rdata[e.port]), 64'(e.data));
        end else begin
            check_eq("rvalid_idle", 64'(rvalid), 64'(0));
        end
        if (m_init) begin
            check_eq("init_busy", 64'(busy), 64'(1));
            check_eq("init_gnt", 64'(gnt), 64'(0));
            check_eq("init_req", 64'(sram_req), 64'(1));
            check_eq("init_we", 64'(sram_we), 64'(1));
            check_eq("init_addr", 64'(sram_addr), 64'(m_cnt));
            check_eq("init_wdata", 64'(sram_wdata), 64'(0));
            check_eq("init_be", 64'(sram_be), 64'hF);
        end else begin
            for (int off = 1; off <= NP; off++) begin
                int idx;
                idx = (m_last + off) % NP;
                if (req[idx] && g < 0) g = idx;
            end
            eg = (g >= 0) ? NP'(1 << g) : '0;
            check_eq("gnt", 64'(gnt), 64'(eg));
            check_eq("run_busy", 64'(busy), 64'(0));
            check_eq("run_req", 64'(sram_req), 64'(|req));
            if (g >= 0) begin
                check_eq("mux_addr", 64'(sram_addr), 64'(addr[g]));
                check_eq("mux_we", 64'(sram_we), 64'(we[g]));
                if (we[g]) begin
                    check_eq("mux_wdata", 64'(sram_wdata), 64'(wdata[g]));
                    check_eq("mux_be", 64'(sram_be), 64'(be[g]));
                end
                e.port = g;
                e.rd   = !we[g];
                e.data = ref_mem[addr[g]];
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        if (m_init) begin
            ref_mem[m_cnt] = '0;
            if (clr) m_cnt = 0;
            else if (m_cnt == NW - 1) begin
                m_init = 1'b0;
                m_cnt  = 0;
            end else m_cnt++;
        end else begin
            if (g >= 0) begin
                m_last = g;
                if (we[g])
                    for (int b = 0; b < BW; b++)
                        if (be[g][b]) ref_mem[addr[g]][8*b +: 8] = wdata[g][8*b +: 8];
            end
            if (clr) begin
                m_init = 1'b1;
                m_cnt  = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            #1;
            check_eq("rst_gnt", 64'(gnt), 64'(0));
            check_eq("rst_rvalid", 64'(rvalid), 64'(0));
            check_eq("rst_sram_req", 64'(sram_req), 64'(0));
            check_eq("rst_busy", 64'(busy), 64'(1));
            @(posedge clk);
            @(negedge clk);
        end
        m_init = 1'b1;
        m_cnt  = 0;
        m_last = NP - 1;
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    // Runs until busy drops (bounded); the final tick is the first RUN cycle.
    task automatic run_init(output int n);
        bit done;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (obs_busy) n++;
            else done = 1'b1;
        end
        if (!done) check_eq("init_timeout", 64'(0), 64'(1));
    endtask

    task automatic drive(input int p, input bit w, input int a, input logic [DW-1:0] d,
                         input logic [BW-1:0] b);
        we[p]    = w;
        addr[p]  = AW'(a);
        wdata[p] = d;
        be[p]    = b;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int total;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        clr   = 1'b0;
        @(negedge clk);
        apply_reset(2);

        // Reset/init with both ports requesting; first RUN tick must grant port 0.
        req = 2'b11;
        drive(0, 1'b0, 0, '0, '0);
        drive(1, 1'b0, 1, '0, '0);
        run_init(n);
        check_eq("init_len", 64'(n), 64'(8));

        // Fairness.
        repeat (6) tick();
        req = 2'b00;
        tick();

        // Port 1 writes, port 0 reads back.
        req = 2'b10;
        drive(1, 1'b1, 3, 32'hA5A5_A5A5, 4'hF);
        tick();
        req = 2'b01;
        drive(0, 1'b0, 3, '0, '0);
        tick();
        req = 2'b00;
        tick();

        // Partial byte-enable write.
        req = 2'b01;
        drive(0, 1'b1, 5, 32'hFFFF_FFFF, 4'h1);
        tick();
        drive(0, 1'b0, 5, '0, '0);
        tick();
        req = 2'b00;
        tick();

        // Clear while granting a read; the rvalid lands in the first INIT cycle.
        req = 2'b01;
        drive(0, 1'b0, 3, '0, '0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        req = 2'b00;
        run_init(n);
        check_eq("clear_init_len", 64'(n), 64'(8));
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();

        // Re-clear during INIT after four writes.
        clr = 1'b1;
        tick();
        clr   = 1'b0;
        total = 0;
        repeat (3) begin
            tick();
            if (obs_busy) total++;
        end
        clr = 1'b1;
        tick();
        if (obs_busy) total++;
        clr = 1'b0;
        run_init(n);
        check_eq("reclear_len", 64'(total + n), 64'(12));

        // Reset in the middle of INIT.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (3) tick();
        req = 2'b11;
        drive(0, 1'b0, 5, '0, '0);
        drive(1, 1'b0, 2, '0, '0);
        apply_reset(1);
        run_init(n);
        check_eq("rst_init_len", 64'(n), 64'(8));
        repeat (2) tick();
        req = 2'b00;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
